call_frame_ctrl: RTL

- Sequences WebAssembly call/return against the operand stack, which also holds locals.
- Keeps a private frame stack of {return PC, frame base, result count, local count} and drives the stack's call, return, allocate-size and stack-tag controls.
- Turns a local index into an absolute stack address and raises traps on frame or stack overflow.
- Sits between the decoder/PC unit and the operand stack.

---
 rtl/call_frame_ctrl_pkg.sv | 42 ++++
 rtl/call_frame_ctrl_frame_stack_ram.sv | 24 ++
 rtl/call_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/call_frame_ctrl_pkg.sv
// Shared widths, state/trap encodings and frame record layout for the call/return controller.
package call_frame_ctrl_pkg;

  localparam int unsigned FRAME_DEPTH = 32;
  localparam int unsigned FRAME_AW    = 5;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned ST_AW       = 5;
  localparam int unsigned ST_DEPTH    = 32;
  localparam int unsigned CNT_W       = 8;

  localparam int unsigned ADDR_W  = ST_AW + 1;
  localparam int unsigned DEPTH_W = FRAME_AW + 1;
  // Overflow check width: wide enough that top_pointer + local_cnt never wraps.
  localparam int unsigned CHK_W   = (ST_AW + 2 > CNT_W + 1) ? ST_AW + 2 : CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALL_EXEC,
    ST_RET_EXEC,
    ST_HALTED,
    ST_TRAPPED
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE      = 2'd0,
    TRAP_FRAME_OVF = 2'd1,
    TRAP_PARAM_UNF = 2'd2,
    TRAP_STACK_OVF = 2'd3
  } trap_e;

  // One saved frame: where to resume plus the caller's frame context.
  typedef struct packed {
    logic [PC_W-1:0]  ret_pc;
    logic [ST_AW:0]   base;
    logic [CNT_W-1:0] n_param;
    logic [CNT_W-1:0] n_local;
    logic             res;
  } frame_rec_t;

  localparam int unsigned FRAME_REC_W = $bits(frame_rec_t);

endpackage

// File: rtl/call_frame_ctrl_frame_stack_ram.sv
// Private frame stack storage: synchronous push write, combinational read of the top entry.
module call_frame_ctrl_frame_stack_ram
  import call_frame_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                push_i,
  input  logic [FRAME_AW-1:0] wr_addr_i,
  input  frame_rec_t          wr_data_i,
  input  logic [FRAME_AW-1:0] rd_addr_i,
  output frame_rec_t          rd_data_o
);

  frame_rec_t mem_q [FRAME_DEPTH];

  // Write the pushed record; contents need no reset since depth gates every read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/call_frame_ctrl.sv
// Sequences WebAssembly call/return against the operand stack and tracks the active frame.
module call_frame_ctrl
  import call_frame_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [CNT_W-1:0]  param_cnt,
  input  logic [CNT_W-1:0]  local_cnt,
  input  logic              result_cnt,
  input  logic [PC_W-1:0]   ret_pc_in,
  output logic              call_ack,
  output logic              ret_ack,
  output logic              pc_redirect,
  output logic [PC_W-1:0]   pc_target,
  output logic              halt,
  output logic              trap,
  output logic [1:0]        trap_code,
  input  logic [ST_AW:0]    top_pointer,
  output logic              os_call,
  output logic              os_return,
  output logic [CNT_W-1:0]  os_alloc_size,
  output logic [ST_AW-1:0]  os_stack_tag,
  output logic              os_push_num,
  output logic              os_push_sel_result,
  input  logic [CNT_W-1:0]  local_idx,
  output logic [ST_AW:0]    local_addr,
  output logic              local_oob,
  output logic [FRAME_AW:0] depth
);

  state_e            state_q, state_d;
  logic [FRAME_AW:0] depth_q, depth_d;
  logic [ST_AW:0]    cur_base_q, cur_base_d;
  logic [CNT_W-1:0]  cur_param_q, cur_param_d;
  logic [CNT_W-1:0]  cur_local_q, cur_local_d;
  logic              cur_res_q, cur_res_d;

  logic [PC_W-1:0]   lat_ret_pc_q, lat_ret_pc_d;
  logic [CNT_W-1:0]  lat_param_q, lat_param_d;
  logic [CNT_W-1:0]  lat_local_q, lat_local_d;
  logic              lat_res_q, lat_res_d;
  logic [ST_AW:0]    new_base_q, new_base_d;

  logic              call_ack_q, call_ack_d;
  logic              ret_ack_q, ret_ack_d;
  logic              pc_redirect_q, pc_redirect_d;
  logic [PC_W-1:0]   pc_target_q, pc_target_d;
  logic              halt_q, halt_d;
  logic              trap_q, trap_d;
  logic [1:0]        trap_code_q, trap_code_d;
  logic              os_call_q, os_call_d;
  logic              os_return_q, os_return_d;
  logic [CNT_W-1:0]  os_alloc_size_q, os_alloc_size_d;
  logic [ST_AW-1:0]  os_stack_tag_q, os_stack_tag_d;
  logic              os_push_num_q, os_push_num_d;
  logic              os_push_sel_q, os_push_sel_d;

  logic              frame_push;
  frame_rec_t        wr_rec;
  frame_rec_t        rd_rec;

  call_frame_ctrl_frame_stack_ram u_frame_ram (
    .clk       (clk),
    .push_i    (frame_push),
    .wr_addr_i (FRAME_AW'(depth_q)),
    .wr_data_i (wr_rec),
    .rd_addr_i (FRAME_AW'(depth_q - DEPTH_W'(1))),
    .rd_data_o (rd_rec)
  );

  // State, frame context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      depth_q         <= '0;
      cur_base_q      <= '0;
      cur_param_q     <= '0;
      cur_local_q     <= '0;
      cur_res_q       <= 1'b0;
      lat_ret_pc_q    <= '0;
      lat_param_q     <= '0;
      lat_local_q     <= '0;
      lat_res_q       <= 1'b0;
      new_base_q      <= '0;
      call_ack_q      <= 1'b0;
      ret_ack_q       <= 1'b0;
      pc_redirect_q   <= 1'b0;
      pc_target_q     <= '0;
      halt_q          <= 1'b0;
      trap_q          <= 1'b0;
      trap_code_q     <= '0;
      os_call_q       <= 1'b0;
      os_return_q     <= 1'b0;
      os_alloc_size_q <= '0;
      os_stack_tag_q  <= '0;
      os_push_num_q   <= 1'b0;
      os_push_sel_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      depth_q         <= depth_d;
      cur_base_q      <= cur_base_d;
      cur_param_q     <= cur_param_d;
      cur_local_q     <= cur_local_d;
      cur_res_q       <= cur_res_d;
      lat_ret_pc_q    <= lat_ret_pc_d;
      lat_param_q     <= lat_param_d;
      lat_local_q     <= lat_local_d;
      lat_res_q       <= lat_res_d;
      new_base_q      <= new_base_d;
      call_ack_q      <= call_ack_d;
      ret_ack_q       <= ret_ack_d;
      pc_redirect_q   <= pc_redirect_d;
      pc_target_q     <= pc_target_d;
      halt_q          <= halt_d;
      trap_q          <= trap_d;
      trap_code_q     <= trap_code_d;
      os_call_q       <= os_call_d;
      os_return_q     <= os_return_d;
      os_alloc_size_q <= os_alloc_size_d;
      os_stack_tag_q  <= os_stack_tag_d;
      os_push_num_q   <= os_push_num_d;
      os_push_sel_q   <= os_push_sel_d;
    end
  end

  // Next state; pulse outputs are loaded on the edge entering their execute cycle.
  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    cur_base_d      = cur_base_q;
    cur_param_d     = cur_param_q;
    cur_local_d     = cur_local_q;
    cur_res_d       = cur_res_q;
    lat_ret_pc_d    = lat_ret_pc_q;
    lat_param_d     = lat_param_q;
    lat_local_d     = lat_local_q;
    lat_res_d       = lat_res_q;
    new_base_d      = new_base_q;
    call_ack_d      = 1'b0;
    ret_ack_d       = 1'b0;
    pc_redirect_d   = 1'b0;
    pc_target_d     = '0;
    halt_d          = halt_q;
    trap_d          = trap_q;
    trap_code_d     = trap_code_q;
    os_call_d       = 1'b0;
    os_return_d     = 1'b0;
    os_alloc_size_d = '0;
    os_stack_tag_d  = '0;
    os_push_num_d   = 1'b0;
    os_push_sel_d   = 1'b0;
    frame_push      = 1'b0;
    wr_rec          = '{ret_pc: lat_ret_pc_q, base: cur_base_q, n_param: cur_param_q,
                        n_local: cur_local_q, res: cur_res_q};

    unique case (state_q)
      ST_IDLE: begin
        if (call_req) begin
          lat_ret_pc_d = ret_pc_in;
          lat_param_d  = param_cnt;
          lat_local_d  = local_cnt;
          lat_res_d    = result_cnt;
          if (depth_q == DEPTH_W'(FRAME_DEPTH)) begin
            state_d     = ST_TRAPPED;
            trap_d      = 1'b1;
            trap_code_d = TRAP_FRAME_OVF;
          end else if (CHK_W'(top_pointer) < CHK_W'(param_cnt)) begin
            state_d     = ST_TRAPPED;
            trap_d      = 1'b1;
            trap_code_d = TRAP_PARAM_UNF;
          end else if (CHK_W'(top_pointer) + CHK_W'(local_cnt) > CHK_W'(ST_DEPTH)) begin
            state_d     = ST_TRAPPED;
            trap_d      = 1'b1;
            trap_code_d = TRAP_STACK_OVF;
          end else begin
            state_d         = ST_CALL_EXEC;
            new_base_d      = top_pointer - ADDR_W'(param_cnt);
            call_ack_d      = 1'b1;
            os_call_d       = 1'b1;
            os_alloc_size_d = local_cnt;
          end
        end else if (ret_req) begin
          if (depth_q == '0) begin
            state_d   = ST_HALTED;
            halt_d    = 1'b1;
            ret_ack_d = 1'b1;
          end else if (cur_res_q && (top_pointer == cur_base_q)) begin
            state_d     = ST_TRAPPED;
            trap_d      = 1'b1;
            trap_code_d = TRAP_PARAM_UNF;
          end else begin
            state_d        = ST_RET_EXEC;
            ret_ack_d      = 1'b1;
            pc_redirect_d  = 1'b1;
            pc_target_d    = rd_rec.ret_pc;
            os_return_d    = 1'b1;
            os_stack_tag_d = cur_base_q[ST_AW-1:0];
            os_push_num_d  = cur_res_q;
            os_push_sel_d  = cur_res_q;
          end
        end
      end
      ST_CALL_EXEC: begin
        frame_push  = 1'b1;
        depth_d     = depth_q + DEPTH_W'(1);
        cur_base_d  = new_base_q;
        cur_param_d = lat_param_q;
        cur_local_d = lat_local_q;
        cur_res_d   = lat_res_q;
        state_d     = ST_IDLE;
      end
      ST_RET_EXEC: begin
        depth_d     = depth_q - DEPTH_W'(1);
        cur_base_d  = rd_rec.base;
        cur_param_d = rd_rec.n_param;
        cur_local_d = rd_rec.n_local;
        cur_res_d   = rd_rec.res;
        state_d     = ST_IDLE;
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TRAPPED: state_d = ST_TRAPPED;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Local index to absolute stack address, with a range flag against the frame's locals.
  always_comb begin
    local_addr = cur_base_q + ADDR_W'(local_idx);
    local_oob  = (CHK_W'(local_idx) >= (CHK_W'(cur_param_q) + CHK_W'(cur_local_q)));
  end

  assign call_ack           = call_ack_q;
  assign ret_ack            = ret_ack_q;
  assign pc_redirect        = pc_redirect_q;
  assign pc_target          = pc_target_q;
  assign halt               = halt_q;
  assign trap               = trap_q;
  assign trap_code          = trap_code_q;
  assign os_call            = os_call_q;
  assign os_return          = os_return_q;
  assign os_alloc_size      = os_alloc_size_q;
  assign os_stack_tag       = os_stack_tag_q;
  assign os_push_num        = os_push_num_q;
  assign os_push_sel_result = os_push_sel_q;
  assign depth              = depth_q;

endmodule
